spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 217 +++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI (mode 0) serial-flash responder: RDSR (0x05), READ (0x03) and, with
// FLASH_RESP_JEDEC_EN defined, JEDEC ID (0x9F). All SPI inputs are resampled into clk.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flash_sck,
  input  logic        flash_cs_n,
  input  logic        flash_si,
  output logic        flash_so,
  output logic        flash_so_oe,
  input  logic [7:0]  status,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        cmd_error,
  output logic [2:0]  dbg_state
);

`ifdef FLASH_RESP_JEDEC_EN
  localparam bit JEDEC_EN = 1'b1;
`else
  localparam bit JEDEC_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_IGNORE = 3'd4;

  localparam logic [1:0] M_STATUS = 2'd0;
  localparam logic [1:0] M_READ   = 2'd1;
  localparam logic [1:0] M_ID     = 2'd2;

  logic        sck_s1, sck_s2, sck_d;
  logic        cs_s1, cs_s2, cs_d;
  logic        si_s1, si_s2;
  logic [1:0]  prime_cnt;
  logic        sync_ok;
  logic        sck_rise, sck_fall, cs_fall, cs_rise;

  logic [2:0]  state;
  logic [1:0]  mode;
  logic [4:0]  bit_cnt;
  logic [22:0] shift_in;
  logic [23:0] rx_word;
  logic [7:0]  tx_shift;
  logic [1:0]  id_idx;
  logic [7:0]  id_byte;
  logic        rd_pend;

  // prime_cnt holds off chip-select edge detection until the synchronizer
  // carries real samples, so a cs_n held low through reset is not seen as a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1    <= 1'b0;
      sck_s2    <= 1'b0;
      sck_d     <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_d      <= 1'b1;
      si_s1     <= 1'b0;
      si_s2     <= 1'b0;
      prime_cnt <= 2'd0;
    end else begin
      sck_s1    <= flash_sck;
      sck_s2    <= sck_s1;
      sck_d     <= sck_s2;
      cs_s1     <= flash_cs_n;
      cs_s2     <= cs_s1;
      cs_d      <= cs_s2;
      si_s1     <= flash_si;
      si_s2     <= si_s1;
      prime_cnt <= (prime_cnt == 2'd3) ? prime_cnt : prime_cnt + 2'd1;
    end
  end

  assign sync_ok   = (prime_cnt == 2'd3);
  assign sck_rise  = sck_s2 & ~sck_d & ~cs_s2;
  assign sck_fall  = ~sck_s2 & sck_d & ~cs_s2;
  assign cs_fall   = sync_ok & cs_d & ~cs_s2;
  assign cs_rise   = cs_s2 & ~cs_d;
  assign rx_word   = {shift_in, si_s2};
  assign dbg_state = state;

  always_comb begin
    id_byte = JEDEC_ID[7:0];
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  end

  // Each response byte is loaded into tx_shift on the 8th rising edge of the
  // previous byte; falling edges then shift it out MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mode        <= M_STATUS;
      bit_cnt     <= 5'd0;
      shift_in    <= 23'd0;
      tx_shift    <= 8'd0;
      id_idx      <= 2'd0;
      rd_pend     <= 1'b0;
      flash_so    <= 1'b0;
      flash_so_oe <= 1'b0;
      mem_addr    <= 24'd0;
      mem_rd      <= 1'b0;
      cmd_error   <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      cmd_error <= 1'b0;
      rd_pend   <= mem_rd;
      if (rd_pend) tx_shift <= mem_data;
      if (cs_rise) begin
        state       <= S_IDLE;
        bit_cnt     <= 5'd0;
        shift_in    <= 23'd0;
        tx_shift    <= 8'd0;
        flash_so    <= 1'b0;
        flash_so_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state    <= S_CMD;
              bit_cnt  <= 5'd0;
              shift_in <= 23'd0;
            end
          end
          S_CMD: begin
            if (sck_rise) begin
              shift_in <= rx_word[22:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                case (rx_word[7:0])
                  8'h05: begin
                    state    <= S_DATA;
                    mode     <= M_STATUS;
                    tx_shift <= status;
                  end
                  8'h03: begin
                    state <= S_ADDR;
                    mode  <= M_READ;
                  end
                  8'h9F: begin
                    if (JEDEC_EN) begin
                      state    <= S_DATA;
                      mode     <= M_ID;
                      tx_shift <= JEDEC_ID[23:16];
                      id_idx   <= 2'd1;
                    end else begin
                      state     <= S_IGNORE;
                      cmd_error <= 1'b1;
                    end
                  end
                  default: begin
                    state     <= S_IGNORE;
                    cmd_error <= 1'b1;
                  end
                endcase
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              shift_in <= rx_word[22:0];
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= 5'd0;
                mem_addr <= rx_word;
                mem_rd   <= 1'b1;
                state    <= S_DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_DATA: begin
            if (sck_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                case (mode)
                  M_STATUS: tx_shift <= status;
                  M_READ: begin
                    mem_addr <= mem_addr + 24'd1;
                    mem_rd   <= 1'b1;
                  end
                  default: begin
                    tx_shift <= id_byte;
                    id_idx   <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                  end
                endcase
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end else if (sck_fall) begin
              flash_so    <= tx_shift[7];
              flash_so_oe <= 1'b1;
              tx_shift    <= {tx_shift[6:0], 1'b0};
            end
          end
          S_IGNORE: begin
            flash_so    <= 1'b0;
            flash_so_oe <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: an SPI initiator driver pushes expected
// {oe_bits, data_bits} per byte and expected mem_rd addresses; monitors pop and compare.
`timescale 1ns/1ps
module tb_spi_flash_responder;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flash_sck = 1'b0;
  logic        flash_cs_n = 1'b1;
  logic        flash_si = 1'b0;
  logic        flash_so;
  logic        flash_so_oe;
  logic [7:0]  status = 8'h00;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        cmd_error;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int err_cycles = 0;

  logic [15:0] exp_q[$];
  logic [23:0] exp_addr_q[$];
  logic [15:0] exp_w;
  logic [23:0] exp_a;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_word = 16'h0;
  logic [7:0]  rx_b, oe_b;

  // clock / reset
  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk        (clk),
    .rst        (rst),
    .flash_sck  (flash_sck),
    .flash_cs_n (flash_cs_n),
    .flash_si   (flash_si),
    .flash_so   (flash_so),
    .flash_so_oe(flash_so_oe),
    .status     (status),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .cmd_error  (cmd_error),
    .dbg_state  (dbg_state)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] + a[23:16];
  endfunction

  // backing store: data valid the cycle after the strobe
  always @(posedge clk or posedge rst) begin
    if (rst) mem_data <= 8'h00;
    else if (mem_rd) mem_data <= mem_byte(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitors
  always @(posedge clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spi_byte_unexpected: got %h expected none", rx_word);
      end else begin
        exp_w = exp_q.pop_front();
        check("spi_byte {oe,so}", {16'h0, rx_word}, {16'h0, exp_w});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_rd) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_rd_unexpected: got addr %h expected none", mem_addr);
      end else begin
        exp_a = exp_addr_q.pop_front();
        check("mem_rd_addr", {8'h0, mem_addr}, {8'h0, exp_a});
      end
    end
    if (cmd_error) err_cycles++;
  end

  // driver tasks
  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] rx, output logic [7:0] oe);
    rx = 8'h00;
    oe = 8'h00;
    for (int i = 0; i < n; i++) begin
      flash_si = tx[7-i];
      #HALF;
      rx = {rx[6:0], flash_so};
      oe = {oe[6:0], flash_so_oe};
      flash_sck = 1'b1;
      #HALF;
      flash_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    logic [7:0] r, o;
    spi_bits(tx, 8, r, o);
    rx_word  = {o, r};
    rx_valid = 1'b1;
    #10;
    rx_valid = 1'b0;
  endtask

  task automatic cs_low();
    flash_cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    flash_cs_n = 1'b1;
    #HALF;
  endtask

  task automatic push(input logic [7:0] oe, input logic [7:0] d);
    exp_q.push_back({oe, d});
  endtask

  initial begin
    #23;
    check("reset_so", {31'h0, flash_so}, 32'h0);
    check("reset_oe", {31'h0, flash_so_oe}, 32'h0);
    check("reset_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("reset_mem_addr", {8'h0, mem_addr}, 32'h0);
    check("reset_cmd_error", {31'h0, cmd_error}, 32'h0);
    check("reset_state", {29'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // RDSR, constant status
    status = 8'hA5;
    push(8'h00, 8'h00); push(8'hFF, 8'hA5); push(8'hFF, 8'hA5);
    cs_low(); spi_byte(8'h05); spi_byte(8'h00); spi_byte(8'h00); cs_high();

    // RDSR, status sampled at each byte boundary
    status = 8'h3C;
    push(8'h00, 8'h00); push(8'hFF, 8'h3C); push(8'hFF, 8'hC3);
    cs_low(); spi_byte(8'h05); status = 8'hC3; spi_byte(8'h00); spi_byte(8'h00); cs_high();

    // READ from 0x000010
    repeat (4) push(8'h00, 8'h00);
    push(8'hFF, 8'h10); push(8'hFF, 8'h11); push(8'hFF, 8'h12);
    exp_addr_q.push_back(24'h000010); exp_addr_q.push_back(24'h000011);
    exp_addr_q.push_back(24'h000012); exp_addr_q.push_back(24'h000013);
    cs_low();
    spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h10);
    spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00);
    cs_high();

    // READ wrapping at the top of the address space
    repeat (4) push(8'h00, 8'h00);
    push(8'hFF, 8'hFE); push(8'hFF, 8'h00);
    exp_addr_q.push_back(24'hFFFFFF); exp_addr_q.push_back(24'h000000);
    exp_addr_q.push_back(24'h000001);
    cs_low();
    spi_byte(8'h03); spi_byte(8'hFF); spi_byte(8'hFF); spi_byte(8'hFF);
    spi_byte(8'h00); spi_byte(8'h00);
    cs_high();

    // JEDEC ID
`ifdef FLASH_RESP_JEDEC_EN
    push(8'h00, 8'h00); push(8'hFF, 8'hEF); push(8'hFF, 8'h40);
    push(8'hFF, 8'h16); push(8'hFF, 8'hEF);
`else
    repeat (5) push(8'h00, 8'h00);
    exp_err++;
`endif
    cs_low();
    spi_byte(8'h9F); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00);
    cs_high();

    // unsupported opcode
    repeat (3) push(8'h00, 8'h00);
    exp_err++;
    cs_low(); spi_byte(8'h5A); spi_byte(8'h00); spi_byte(8'h00); cs_high();

    // READ aborted after 13 address bits, then RDSR
    push(8'h00, 8'h00);
    cs_low();
    spi_byte(8'h03);
    spi_bits(8'h12, 8, rx_b, oe_b);
    spi_bits(8'hA0, 5, rx_b, oe_b);
    cs_high();
    status = 8'h96;
    push(8'h00, 8'h00); push(8'hFF, 8'h96);
    cs_low(); spi_byte(8'h05); spi_byte(8'h00); cs_high();

    // reset in the middle of an RDSR response
    status = 8'hFF;
    push(8'h00, 8'h00);
    cs_low();
    spi_byte(8'h05);
    spi_bits(8'h00, 4, rx_b, oe_b);
    #40;
    check("mid_rdsr_so", {31'h0, flash_so}, 32'h1);
    check("mid_rdsr_oe", {31'h0, flash_so_oe}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_so", {31'h0, flash_so}, 32'h0);
    check("rst_oe", {31'h0, flash_so_oe}, 32'h0);
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    #9;
    rst = 1'b0;
    #40;
    // cs_n still low: no fresh falling edge, so nothing is decoded
    push(8'h00, 8'h00); push(8'h00, 8'h00);
    spi_byte(8'h05); spi_byte(8'h00);
    cs_high();
    status = 8'h5C;
    push(8'h00, 8'h00); push(8'hFF, 8'h5C);
    cs_low(); spi_byte(8'h05); spi_byte(8'h00); cs_high();

    repeat (10) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("exp_addr_q_drained", exp_addr_q.size(), 32'd0);
    check("cmd_error_cycles", err_cycles, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
